// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, request length
// codes and the address-space tag that marks I/O writes.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } arb_state_t;

   localparam logic [1:0] LEN_1B  = 2'b00;
   localparam logic [1:0] LEN_2B  = 2'b01;
   localparam logic [1:0] LEN_4B  = 2'b10;
   localparam logic [1:0] LEN_BAD = 2'b11;

   localparam logic [1:0] IO_SPACE_HI = 2'b11;

   // The illegal code is served as a full word rather than dropped.
   function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
      case (len)
         LEN_1B:          return 3'd1;
         LEN_2B:          return 3'd2;
         LEN_4B, LEN_BAD: return 3'd4;
         default:         return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin selector: first eligible channel at or after ptr,
// wrapping modulo NUM_CH.
module rr_picker #(
   parameter int NUM_CH = 2,
   parameter int PW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [NUM_CH-1:0] mask,
   input  logic [PW-1:0]     ptr,
   output logic              valid,
   output logic [PW-1:0]     grant
);

   logic [NUM_CH-1:0] elig;

   assign elig = req & mask;

   // Walk from the farthest offset back to ptr so the nearest hit wins.
   always_comb begin
      valid = 1'b0;
      grant = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (elig[(int'(ptr) + i) % NUM_CH]) begin
            valid = 1'b1;
            grant = PW'((int'(ptr) + i) % NUM_CH);
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Byte-serial memory port shared by NUM_CH requesters with round-robin grant,
// flush abort of speculative reads and back-pressure on I/O-space writes.
//
//   state | meaning
//   IDLE  | no access in flight; may grant a channel
//   READ  | issuing read bytes, capturing mem_din one cycle behind
//   WRITE | issuing write bytes, stalling on a full I/O buffer
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int                NUM_CH     = 2,
   parameter logic [NUM_CH-1:0] FLUSH_MASK = NUM_CH'(1),
   parameter logic [1:0]        IO_MASK_HI = IO_SPACE_HI
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  flush,
   input  logic                  io_buffer_full,
   input  logic [NUM_CH-1:0]     req_en,
   input  logic [NUM_CH-1:0]     req_wr,
   input  logic [2*NUM_CH-1:0]   req_len,
   input  logic [32*NUM_CH-1:0]  req_addr,
   input  logic [32*NUM_CH-1:0]  req_wdata,
   output logic [NUM_CH-1:0]     rdy,
   output logic [31:0]           rdata,
   input  logic [7:0]            mem_din,
   output logic [7:0]            mem_dout,
   output logic [31:0]           mem_a,
   output logic                  mem_wr
);

   localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   arb_state_t        state_q, state_d;
   logic [PW-1:0]     ptr_q, ptr_d, own_q, own_d;
   logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [2:0]        nbytes_q, nbytes_d, idx_q, idx_d;
   logic [NUM_CH-1:0] rdy_q, rdy_d;
   logic [31:0]       mem_a_q, mem_a_c;
   logic [7:0]        mem_dout_q, mem_dout_c;
   logic              wr_c;
   logic              pick_valid;
   logic [PW-1:0]     pick_ch;
   logic [NUM_CH-1:0] elig_mask;
   logic [31:0]       cur_addr;
   logic              io_stall;
   logic [1:0]        cap_sel;

   // A channel whose rdy is pulsing still holds req_en this cycle; mask it.
   assign elig_mask = ~rdy_q & (flush ? ~FLUSH_MASK : {NUM_CH{1'b1}});
   assign cur_addr  = addr_q + {29'd0, idx_q};
   assign io_stall  = (cur_addr[17:16] == IO_MASK_HI) && io_buffer_full;
   assign cap_sel   = 2'(idx_q - 3'd1);

   rr_picker #(.NUM_CH(NUM_CH), .PW(PW)) u_picker (
      .req   (req_en),
      .mask  (elig_mask),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .grant (pick_ch)
   );

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      own_d    = own_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      nbytes_d = nbytes_q;
      idx_d    = idx_q;
      rdy_d    = rdy_q;
      if (rdy_in) begin
         rdy_d = '0;
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  own_d    = pick_ch;
                  ptr_d    = (pick_ch == PW'(NUM_CH - 1)) ? '0 : pick_ch + PW'(1);
                  addr_d   = req_addr[32*int'(pick_ch) +: 32];
                  wdata_d  = req_wdata[32*int'(pick_ch) +: 32];
                  nbytes_d = len_to_bytes(req_len[2*int'(pick_ch) +: 2]);
                  idx_d    = '0;
                  if (req_wr[pick_ch]) begin
                     state_d = WRITE;
                  end else begin
                     state_d = READ;
                     rdata_d = '0;
                  end
               end
            end
            READ: begin
               if (flush && FLUSH_MASK[own_q]) begin
                  state_d = IDLE;
               end else begin
                  if (idx_q != 3'd0) rdata_d[{cap_sel, 3'b000} +: 8] = mem_din;
                  if (idx_q == nbytes_q) begin
                     state_d       = IDLE;
                     rdy_d[own_q]  = 1'b1;
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end
            end
            WRITE: begin
               if (!io_stall) begin
                  idx_d = idx_q + 3'd1;
                  if (idx_q == nbytes_q - 3'd1) begin
                     state_d      = IDLE;
                     rdy_d[own_q] = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      mem_a_c    = '0;
      mem_dout_c = '0;
      wr_c       = 1'b0;
      case (state_q)
         READ: if (idx_q != nbytes_q) mem_a_c = cur_addr;
         WRITE: begin
            if (!io_stall) begin
               mem_a_c    = cur_addr;
               mem_dout_c = wdata_q[{idx_q[1:0], 3'b000} +: 8];
               wr_c       = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // While disabled, replay the last issued address so mem_din stays aligned.
   assign mem_a    = rdy_in ? mem_a_c : mem_a_q;
   assign mem_dout = rdy_in ? mem_dout_c : mem_dout_q;
   assign mem_wr   = rdy_in & wr_c;
   assign rdy      = rdy_in ? rdy_q : '0;
   assign rdata    = rdata_q;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         own_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         nbytes_q   <= '0;
         idx_q      <= '0;
         rdy_q      <= '0;
         mem_a_q    <= '0;
         mem_dout_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         own_q    <= own_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         nbytes_q <= nbytes_d;
         idx_q    <= idx_d;
         rdy_q    <= rdy_d;
         if (rdy_in) begin
            mem_a_q    <= mem_a_c;
            mem_dout_q <= mem_dout_c;
         end
      end
   end

endmodule
